// File: rtl/tlv_i2c_pkg.sv
// Shared definitions for the I2C bus arbiter slice.
//   arb_state_t    : arbiter FSM states
//   RECOVER_CYCLES : cycles the master is held in reset after a watchdog abort
//   ADDR_W/DATA_W/NBYTES_W : i2c_master command field widths
package tlv_i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        ACTIVE,
        RELEASE,
        RECOVER
    } arb_state_t;

    localparam int unsigned RECOVER_CYCLES = 4;

    localparam int unsigned ADDR_W   = 7;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NBYTES_W = 8;

endpackage

// File: rtl/i2c_bus_arbiter_rr_pick.sv
// Combinational round-robin priority encoder.
//   req      : per-client request vector
//   last_idx : index served last; search starts at last_idx+1 (mod N)
//   valid    : at least one request present
//   idx      : selected client index
module rr_pick #(
    parameter int unsigned NUM_CLIENTS = 4,
    parameter int unsigned IDX_W       = $clog2(NUM_CLIENTS)
) (
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic [IDX_W-1:0]       last_idx,
    output logic                   valid,
    output logic [IDX_W-1:0]       idx
);

    always_comb begin
        int unsigned cand;
        valid = 1'b0;
        idx   = '0;
        cand  = 0;
        // Offsets 1..N put last_idx itself at lowest priority.
        for (int unsigned k = 1; k <= NUM_CLIENTS; k++) begin
            cand = (32'(last_idx) + k) % NUM_CLIENTS;
            if (!valid && req[IDX_W'(cand)]) begin
                valid = 1'b1;
                idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one i2c_master among NUM_CLIENTS sources.
// Optional watchdog: define I2C_ARB_WATCHDOG_EN to abort grants that exceed
// TIMEOUT_CYCLES and pulse the master reset for RECOVER_CYCLES.
//   clock, reset          : system clock, asynchronous active-high reset
//   req, c_ena            : per-client request level and transaction enable
//   c_addr..c_nbytes      : per-client command fields, client k at slice k
//   grant, done           : one-hot grant, completion pulse
//   timeout_err           : watchdog abort pulse (0 without watchdog)
//   s_byte_counter, s_ack_error : master status, 0 when nothing is granted
//   m_ena..m_nbytes       : command fields to the master, 0 when no grant
//   m_busy, m_byte_counter, m_ack_error : master status inputs
//   m_reset_n             : active-low master reset, low during recovery
module i2c_bus_arbiter
    import tlv_i2c_pkg::*;
#(
    parameter int unsigned NUM_CLIENTS    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned IDX_W          = $clog2(NUM_CLIENTS)
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_CLIENTS-1:0]          req,
    input  logic [NUM_CLIENTS-1:0]          c_ena,
    input  logic [ADDR_W*NUM_CLIENTS-1:0]   c_addr,
    input  logic [NUM_CLIENTS-1:0]          c_rw,
    input  logic [NUM_CLIENTS-1:0]          c_read_only,
    input  logic [DATA_W*NUM_CLIENTS-1:0]   c_data_wr,
    input  logic [NBYTES_W*NUM_CLIENTS-1:0] c_nbytes,
    output logic [NUM_CLIENTS-1:0]          grant,
    output logic [NUM_CLIENTS-1:0]          done,
    output logic [NUM_CLIENTS-1:0]          timeout_err,
    output logic [7:0]                      s_byte_counter,
    output logic                            s_ack_error,
    output logic                            m_ena,
    output logic [ADDR_W-1:0]               m_addr,
    output logic                            m_rw,
    output logic                            m_read_only,
    output logic [DATA_W-1:0]               m_data_wr,
    output logic [NBYTES_W-1:0]             m_nbytes,
    input  logic                            m_busy,
    input  logic [7:0]                      m_byte_counter,
    input  logic                            m_ack_error,
    output logic                            m_reset_n
);

    if (NUM_CLIENTS < 2 || NUM_CLIENTS > 8 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
        $error("i2c_bus_arbiter: NUM_CLIENTS must be 2..8 and TIMEOUT_CYCLES nonzero");
    end

    arb_state_t             state, state_d;
    logic [IDX_W-1:0]       gnt_idx, gnt_idx_d;
    logic [IDX_W-1:0]       last_idx, last_idx_d;
    logic [NUM_CLIENTS-1:0] grant_d, done_d;
    logic                   pick_valid;
    logic [IDX_W-1:0]       pick_idx;

    rr_pick #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .IDX_W       (IDX_W)
    ) u_rr_pick (
        .req      (req),
        .last_idx (last_idx),
        .valid    (pick_valid),
        .idx      (pick_idx)
    );

`ifdef I2C_ARB_WATCHDOG_EN
    localparam int unsigned REC_W = $clog2(RECOVER_CYCLES) + 1;

    logic [31:0]            wd_cnt;
    logic [REC_W-1:0]       rec_cnt;
    logic                   wd_hit, rec_last, in_txn;
    logic [NUM_CLIENTS-1:0] terr_d, terr_q;

    assign in_txn   = (state == GRANT) || (state == ACTIVE) || (state == RELEASE);
    // Counter is 0 in the first GRANT cycle, so the abort lands exactly
    // TIMEOUT_CYCLES cycles after the grant rose.
    assign wd_hit   = in_txn && (wd_cnt >= TIMEOUT_CYCLES - 1);
    assign rec_last = (rec_cnt == REC_W'(RECOVER_CYCLES - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wd_cnt  <= '0;
            rec_cnt <= '0;
            terr_q  <= '0;
        end else begin
            wd_cnt  <= in_txn ? wd_cnt + 32'd1 : '0;
            rec_cnt <= (state == RECOVER) ? rec_cnt + REC_W'(1) : '0;
            terr_q  <= terr_d;
        end
    end

    assign timeout_err = terr_q;
    assign m_reset_n   = (state != RECOVER);
`else
    assign timeout_err = '0;
    assign m_reset_n   = 1'b1;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            gnt_idx  <= '0;
            last_idx <= IDX_W'(NUM_CLIENTS - 1);
            grant    <= '0;
            done     <= '0;
        end else begin
            state    <= state_d;
            gnt_idx  <= gnt_idx_d;
            last_idx <= last_idx_d;
            grant    <= grant_d;
            done     <= done_d;
        end
    end

    always_comb begin
        state_d    = state;
        gnt_idx_d  = gnt_idx;
        last_idx_d = last_idx;
        grant_d    = grant;
        done_d     = '0;
`ifdef I2C_ARB_WATCHDOG_EN
        terr_d     = '0;
`endif
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    gnt_idx_d = pick_idx;
                    grant_d   = {{(NUM_CLIENTS-1){1'b0}}, 1'b1} << pick_idx;
                    state_d   = GRANT;
                end
            end
            GRANT: begin
                if (c_ena[gnt_idx]) begin
                    state_d = ACTIVE;
                end else if (!req[gnt_idx]) begin
                    // Abandoned before starting: no done, round-robin pointer untouched.
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            ACTIVE: begin
                if (!c_ena[gnt_idx]) state_d = RELEASE;
            end
            RELEASE: begin
                if (!m_busy) begin
                    done_d[gnt_idx] = 1'b1;
                    last_idx_d      = gnt_idx;
                    grant_d         = '0;
                    state_d         = IDLE;
                end
            end
`ifdef I2C_ARB_WATCHDOG_EN
            RECOVER: begin
                if (rec_last) state_d = IDLE;
            end
`else
            RECOVER: state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
`ifdef I2C_ARB_WATCHDOG_EN
        // Abort overrides any normal transition in the same cycle.
        if (wd_hit) begin
            state_d         = RECOVER;
            grant_d         = '0;
            done_d          = '0;
            terr_d[gnt_idx] = 1'b1;
            last_idx_d      = gnt_idx;
        end
`endif
    end

    always_comb begin
        m_addr      = '0;
        m_rw        = 1'b0;
        m_read_only = 1'b0;
        m_data_wr   = '0;
        m_nbytes    = '0;
        if (|grant && state != RECOVER) begin
            for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
                if (gnt_idx == IDX_W'(k)) begin
                    m_addr      = c_addr[k*ADDR_W +: ADDR_W];
                    m_rw        = c_rw[k];
                    m_read_only = c_read_only[k];
                    m_data_wr   = c_data_wr[k*DATA_W +: DATA_W];
                    m_nbytes    = c_nbytes[k*NBYTES_W +: NBYTES_W];
                end
            end
        end
        m_ena          = (state == ACTIVE) ? c_ena[gnt_idx] : 1'b0;
        s_byte_counter = |grant ? m_byte_counter : '0;
        s_ack_error    = |grant ? m_ack_error : 1'b0;
    end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Self-checking bench for i2c_bus_arbiter (4 clients, TIMEOUT_CYCLES=100).
// Directed vector table, hand-written corner sequences, and a randomized
// run against a transaction-level reference model. The watchdog sequence
// is compiled only when I2C_ARB_WATCHDOG_EN is defined.
module tb_i2c_bus_arbiter;

    localparam int N = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic [N-1:0]  req, c_ena, c_rw, c_read_only;
    logic [7*N-1:0]  c_addr;
    logic [32*N-1:0] c_data_wr;
    logic [8*N-1:0]  c_nbytes;
    logic [N-1:0]  grant, done, timeout_err;
    logic [7:0]    s_byte_counter;
    logic          s_ack_error;
    logic          m_ena, m_rw, m_read_only;
    logic [6:0]    m_addr;
    logic [31:0]   m_data_wr;
    logic [7:0]    m_nbytes;
    logic          m_busy;
    logic [7:0]    m_byte_counter;
    logic          m_ack_error;
    logic          m_reset_n;

    logic [6:0]  addr_a [N];
    logic        rw_a   [N];
    logic        ro_a   [N];
    logic [31:0] data_a [N];
    logic [7:0]  nb_a   [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            c_addr[i*7 +: 7]     = addr_a[i];
            c_rw[i]              = rw_a[i];
            c_read_only[i]       = ro_a[i];
            c_data_wr[i*32 +: 32] = data_a[i];
            c_nbytes[i*8 +: 8]   = nb_a[i];
        end
    end

    i2c_bus_arbiter #(
        .NUM_CLIENTS    (N),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .req            (req),
        .c_ena          (c_ena),
        .c_addr         (c_addr),
        .c_rw           (c_rw),
        .c_read_only    (c_read_only),
        .c_data_wr      (c_data_wr),
        .c_nbytes       (c_nbytes),
        .grant          (grant),
        .done           (done),
        .timeout_err    (timeout_err),
        .s_byte_counter (s_byte_counter),
        .s_ack_error    (s_ack_error),
        .m_ena          (m_ena),
        .m_addr         (m_addr),
        .m_rw           (m_rw),
        .m_read_only    (m_read_only),
        .m_data_wr      (m_data_wr),
        .m_nbytes       (m_nbytes),
        .m_busy         (m_busy),
        .m_byte_counter (m_byte_counter),
        .m_ack_error    (m_ack_error),
        .m_reset_n      (m_reset_n)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int owner_of(input logic [N-1:0] g);
        for (int i = 0; i < N; i++)
            if (g == (N'(1) << i)) return i;
        return -1;
    endfunction

    task automatic set_fixed_fields();
        for (int i = 0; i < N; i++) begin
            addr_a[i] = 7'h10 + 7'(i);
            rw_a[i]   = i[0];
            ro_a[i]   = (i == 3);
            data_a[i] = 32'hA000_0000 + 32'(i);
            nb_a[i]   = 8'(5 + i);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = '0; c_ena = '0; m_busy = 1'b0;
        m_byte_counter = 8'h5A; m_ack_error = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Waits (bounded) for any grant; returns the granted client or -1.
    task automatic wait_grant(output int who);
        who = -1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clock);
            if (|grant) begin
                who = owner_of(grant);
                return;
            end
        end
        check("grant_wait_expired", 0, 1);
    endtask

    // Runs one transaction for the granted client k with m_busy low.
    task automatic finish_txn(input int k);
        c_ena[k] = 1'b1;
        @(negedge clock);
        #1;
        check("txn_m_ena_active", m_ena, 1);
        c_ena[k] = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clock);
            if (|done) begin
                check("txn_done_client", done, N'(1) << k);
                check("txn_grant_low_at_done", grant, 0);
                return;
            end
        end
        check("done_wait_expired", 0, 1);
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] ena;
        logic         busy;
        logic [N-1:0] exp_grant;
        logic [N-1:0] exp_done;
        logic         exp_mena;
    } vec_t;

    function automatic vec_t mk(input logic [N-1:0] r, input logic [N-1:0] e, input logic b,
                                input logic [N-1:0] g, input logic [N-1:0] d, input logic me);
        vec_t v;
        v.req = r; v.ena = e; v.busy = b;
        v.exp_grant = g; v.exp_done = d; v.exp_mena = me;
        return v;
    endfunction

    // Reference model: who owns the bus, whether the owner has started and
    // stopped its transfer, who was served last, and a pending done pulse.
    int m_owner, m_last, m_done;
    bit m_used, m_closing;

    task automatic model_reset();
        m_owner = -1; m_last = N - 1; m_done = -1; m_used = 0; m_closing = 0;
    endtask

    task automatic model_step();
        m_done = -1;
        if (m_owner < 0) begin
            for (int s = 1; s <= N; s++) begin
                if (m_owner < 0 && req[(m_last + s) % N]) begin
                    m_owner = (m_last + s) % N;
                    m_used = 0; m_closing = 0;
                end
            end
        end else if (!m_used) begin
            if (c_ena[m_owner]) m_used = 1;
            else if (!req[m_owner]) m_owner = -1;
        end else if (!m_closing) begin
            if (!c_ena[m_owner]) m_closing = 1;
        end else if (!m_busy) begin
            m_done = m_owner; m_last = m_owner; m_owner = -1;
        end
    endtask

    task automatic model_compare();
        logic [N-1:0] eg, ed;
        logic         me;
        eg = (m_owner >= 0) ? N'(1) << m_owner : '0;
        ed = (m_done >= 0) ? N'(1) << m_done : '0;
        me = (m_owner >= 0 && m_used && !m_closing) ? c_ena[m_owner] : 1'b0;
        check("rnd_grant", grant, eg);
        check("rnd_done", done, ed);
        check("rnd_m_ena", m_ena, me);
        check("rnd_m_addr",      m_addr,      (m_owner >= 0) ? addr_a[m_owner] : 7'h0);
        check("rnd_m_rw",        m_rw,        (m_owner >= 0) ? rw_a[m_owner]   : 1'b0);
        check("rnd_m_read_only", m_read_only, (m_owner >= 0) ? ro_a[m_owner]   : 1'b0);
        check("rnd_m_data_wr",   m_data_wr,   (m_owner >= 0) ? data_a[m_owner] : 32'h0);
        check("rnd_m_nbytes",    m_nbytes,    (m_owner >= 0) ? nb_a[m_owner]   : 8'h0);
        check("rnd_s_byte_counter", s_byte_counter, (m_owner >= 0) ? m_byte_counter : 8'h0);
        check("rnd_s_ack_error",    s_ack_error,    (m_owner >= 0) ? m_ack_error    : 1'b0);
        check("rnd_timeout_err", timeout_err, 0);
        check("rnd_m_reset_n", m_reset_n, 1);
    endtask

    vec_t vecs[18];
    int   ph  [N];
    int   cnt [N];

    initial begin
        int w, o, busy_run, cycles, lows;
        logic [N-1:0] g_obs, d_obs;

        set_fixed_fields();
        do_reset();

        // Directed table: single client 2, abandon in GRANT, client 0 after.
        vecs[0]  = mk(4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0);
        vecs[1]  = mk(4'b0100, 4'b0100, 0, 4'b0000, 4'b0000, 0);
        vecs[2]  = mk(4'b0100, 4'b0100, 0, 4'b0100, 4'b0000, 0);
        vecs[3]  = mk(4'b0100, 4'b0100, 1, 4'b0100, 4'b0000, 1);
        vecs[4]  = mk(4'b0100, 4'b0000, 1, 4'b0100, 4'b0000, 0);
        vecs[5]  = mk(4'b0100, 4'b0000, 1, 4'b0100, 4'b0000, 0);
        vecs[6]  = mk(4'b0100, 4'b0000, 0, 4'b0100, 4'b0000, 0);
        vecs[7]  = mk(4'b0000, 4'b0000, 0, 4'b0000, 4'b0100, 0);
        vecs[8]  = mk(4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0);
        vecs[9]  = mk(4'b1001, 4'b0000, 0, 4'b0000, 4'b0000, 0);
        vecs[10] = mk(4'b1001, 4'b0000, 0, 4'b1000, 4'b0000, 0);
        vecs[11] = mk(4'b0001, 4'b0000, 0, 4'b1000, 4'b0000, 0);
        vecs[12] = mk(4'b0001, 4'b0000, 0, 4'b0000, 4'b0000, 0);
        vecs[13] = mk(4'b0001, 4'b0001, 0, 4'b0001, 4'b0000, 0);
        vecs[14] = mk(4'b0001, 4'b0001, 1, 4'b0001, 4'b0000, 1);
        vecs[15] = mk(4'b0001, 4'b0000, 0, 4'b0001, 4'b0000, 0);
        vecs[16] = mk(4'b0001, 4'b0000, 0, 4'b0001, 4'b0000, 0);
        vecs[17] = mk(4'b0000, 4'b0000, 0, 4'b0000, 4'b0001, 0);

        for (int i = 0; i < 18; i++) begin
            @(negedge clock);
            req = vecs[i].req; c_ena = vecs[i].ena; m_busy = vecs[i].busy;
            #1;
            o = owner_of(vecs[i].exp_grant);
            check($sformatf("vec%0d_grant", i), grant, vecs[i].exp_grant);
            check($sformatf("vec%0d_done", i), done, vecs[i].exp_done);
            check($sformatf("vec%0d_m_ena", i), m_ena, vecs[i].exp_mena);
            check($sformatf("vec%0d_m_addr", i), m_addr, (o >= 0) ? addr_a[o] : 7'h0);
            check($sformatf("vec%0d_m_nbytes", i), m_nbytes, (o >= 0) ? nb_a[o] : 8'h0);
            check($sformatf("vec%0d_s_byte_counter", i), s_byte_counter, (o >= 0) ? 8'h5A : 8'h0);
            if (i == 0) begin
                check("reset_timeout_err", timeout_err, 0);
                check("reset_m_reset_n", m_reset_n, 1);
                check("reset_s_ack_error", s_ack_error, 0);
            end
        end

        // All four request from reset: order 0,1,2,3,0; requests stay high
        // through done, so each client re-requests in its own done cycle.
        do_reset();
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            wait_grant(w);
            check($sformatf("rr_order_%0d", t), w, t % N);
            if (w >= 0) finish_txn(w);
        end
        req = '0;

        // Client 1 holds req; client 3 joins and is served before client 1 again.
        do_reset();
        req = 4'b0010;
        wait_grant(w);
        check("hold_first_grant", w, 1);
        req = 4'b1010;
        if (w >= 0) finish_txn(w);
        wait_grant(w);
        check("hold_second_grant", w, 3);
        if (w >= 0) finish_txn(w);
        wait_grant(w);
        check("hold_third_grant", w, 1);
        req = 4'b0000;
        if (w >= 0) finish_txn(w);

        // Asynchronous reset while ACTIVE.
        do_reset();
        req = 4'b0100;
        wait_grant(w);
        check("rst_mid_grant", w, 2);
        c_ena = 4'b0100; m_busy = 1'b1;
        @(negedge clock);
        #1;
        check("rst_mid_m_ena_before", m_ena, 1);
        check("rst_mid_m_addr_before", m_addr, addr_a[2]);
        #1 reset = 1'b1;
        #1;
        check("rst_mid_grant_now", grant, 0);
        check("rst_mid_m_ena_now", m_ena, 0);
        check("rst_mid_m_addr_now", m_addr, 0);
        check("rst_mid_m_data_now", m_data_wr, 0);
        check("rst_mid_m_nbytes_now", m_nbytes, 0);
        check("rst_mid_m_rw_now", m_rw, 0);
        check("rst_mid_done_now", done, 0);
        check("rst_mid_m_reset_n", m_reset_n, 1);
        @(negedge clock);
        reset = 1'b0; c_ena = '0; m_busy = 1'b0; req = 4'b1111;
        wait_grant(w);
        check("rst_first_grant_client0", w, 0);
        req = 4'b0000;
        @(negedge clock);
        check("abandon_grant_cleared", grant, 0);
        check("abandon_no_done", done, 0);

`ifdef I2C_ARB_WATCHDOG_EN
        // Hung master: m_busy stuck high.
        do_reset();
        m_busy = 1'b1;
        req = 4'b0001;
        wait_grant(w);
        check("wd_grant", w, 0);
        c_ena = 4'b0001;
        cycles = 0;
        while (cycles < 200 && timeout_err == '0) begin
            @(negedge clock);
            cycles++;
            if (cycles == 1) c_ena = '0;
        end
        check("wd_cycles_to_timeout", cycles, 100);
        check("wd_timeout_err", timeout_err, 4'b0001);
        check("wd_grant_cleared", grant, 0);
        check("wd_m_addr_forced", m_addr, 0);
        req = '0;
        lows = 0;
        while (lows < 20 && m_reset_n == 1'b0) begin
            lows++;
            @(negedge clock);
            if (lows == 1) check("wd_timeout_err_single", timeout_err, 0);
        end
        check("wd_reset_low_cycles", lows, 4);
        m_busy = 1'b0;
        req = 4'b0011;
        wait_grant(w);
        check("wd_next_grant_after_recover", w, 1);
        req = '0;
        @(negedge clock);
`endif

        // Randomized run against the reference model.
        do_reset();
        model_reset();
        busy_run = 0;
        for (int i = 0; i < N; i++) begin ph[i] = 0; cnt[i] = 0; end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clock);
            g_obs = grant; d_obs = done;
            for (int k = 0; k < N; k++) begin
                case (ph[k])
                    0: begin
                        req[k] = 1'b0;
                        c_ena[k] = ($urandom_range(3) == 0);
                        if ($urandom_range(3) == 0) begin
                            req[k] = 1'b1; ph[k] = 1; cnt[k] = $urandom_range(3);
                        end
                    end
                    1: begin
                        if (g_obs[k]) begin
                            if (c_ena[k]) begin
                                ph[k] = 2; cnt[k] = 1 + $urandom_range(5);
                            end else if ($urandom_range(7) == 0) begin
                                req[k] = 1'b0; ph[k] = 0;
                            end else if (cnt[k] == 0) begin
                                c_ena[k] = 1'b1;
                            end else begin
                                cnt[k]--;
                            end
                        end
                    end
                    2: begin
                        cnt[k]--;
                        if (cnt[k] <= 0) begin c_ena[k] = 1'b0; ph[k] = 3; end
                    end
                    default: begin
                        if (d_obs[k]) begin
                            req[k] = 1'b0; ph[k] = 0;
                            if ($urandom_range(1) == 0) begin
                                req[k] = 1'b1; ph[k] = 1; cnt[k] = $urandom_range(3);
                            end
                        end
                    end
                endcase
                addr_a[k] = 7'($urandom); rw_a[k] = 1'($urandom);
                ro_a[k] = 1'($urandom); data_a[k] = $urandom; nb_a[k] = 8'($urandom);
            end
            m_busy = (busy_run >= 5) ? 1'b0 : 1'($urandom);
            busy_run = m_busy ? busy_run + 1 : 0;
            m_byte_counter = 8'($urandom);
            m_ack_error = 1'($urandom);
            #1;
            model_compare();
            model_step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
